// File: rtl/action_egress_if.sv
// Packet ingress/egress bundle for action_egress: upstream word + action/state in,
// handshaked egress word, port mask and status counters out.
interface action_egress_if;
    logic         pkt_vld_in;
    logic [511:0] pkt_data_in;
    logic [15:0]  action_in;
    logic [7:0]   state_in;
    logic         nearly_full;
    logic         pkt_vld_out;
    logic         pkt_rdy_in;
    logic [511:0] pkt_data_out;
    logic [7:0]   port_out;
    logic [15:0]  drop_cnt;
    logic [15:0]  ovf_cnt;

    modport master (
        output pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
        input  nearly_full, pkt_vld_out, pkt_data_out, port_out, drop_cnt, ovf_cnt
    );

    modport slave (
        input  pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
        output nearly_full, pkt_vld_out, pkt_data_out, port_out, drop_cnt, ovf_cnt
    );
endinterface

// File: rtl/action_egress.sv
// Egress stage after the stateful match/action block: FIFO-buffers words, decodes the action
// (drop / forward / punt) and drives a valid/ready egress port. Optional macro: STATE_STAMP_EN.
module action_egress #(
    parameter int unsigned DEPTH_BITS = 4,
    parameter logic [7:0]  CPU_PORT   = 8'h80,
    parameter int unsigned NF_MARGIN  = 2
) (
    input logic            clk,
    input logic            reset,
    action_egress_if.slave bus
);

    localparam int unsigned Depth  = 2 ** DEPTH_BITS;
    localparam int unsigned EntryW = 512 + 16 + 8;

    localparam logic [DEPTH_BITS-1:0] PtrOne   = {{(DEPTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS:0]   CntOne   = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS:0]   CntDepth = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0]   CntNf    = (DEPTH_BITS + 1)'(NF_MARGIN);

    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

    logic [EntryW-1:0]     mem [Depth];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q, count_d;
    state_e                state_q;

    logic         vld_q;
    logic [511:0] data_q;
    logic [7:0]   port_q;
    logic [15:0]  drop_q, ovf_q;
    logic         nf_q;

    logic         full, empty, rd_en, wr_en, lost;
    logic [511:0] head_data, out_data;
    logic [15:0]  head_action;
    logic [7:0]   head_state, dest;
    logic         is_drop;

    assign full  = (count_q == CntDepth);
    assign empty = (count_q == '0);
    assign rd_en = (state_q == StFetch) && !empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr_en = bus.pkt_vld_in && (!full || rd_en);
    assign lost  = bus.pkt_vld_in && !wr_en;

    assign {head_data, head_action, head_state} = mem[rd_ptr_q];

    assign is_drop = (head_action == 16'h0000);
    assign dest    = (head_action[15:8] != 8'h00) ? head_action[15:8] : CPU_PORT;

`ifdef STATE_STAMP_EN
    assign out_data = {head_state, head_data[503:0]};
`else
    logic unused_head_state;
    assign unused_head_state = ^head_state;
    assign out_data = head_data;
`endif

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CntOne;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {bus.pkt_data_in, bus.action_in, bus.state_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            nf_q     <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
            if (lost && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            nf_q <= (CntDepth - count_d) <= CntNf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            vld_q   <= 1'b0;
            data_q  <= '0;
            port_q  <= '0;
            drop_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) state_q <= StFetch;
                end
                StFetch: begin
                    if (!rd_en) begin
                        state_q <= StIdle;
                    end else if (is_drop) begin
                        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                        state_q <= (count_d != '0) ? StFetch : StIdle;
                    end else begin
                        vld_q   <= 1'b1;
                        data_q  <= out_data;
                        port_q  <= dest;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (bus.pkt_rdy_in) begin
                        vld_q   <= 1'b0;
                        state_q <= (count_d != '0) ? StFetch : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.pkt_vld_out  = vld_q;
    assign bus.pkt_data_out = data_q;
    assign bus.port_out     = port_q;
    assign bus.drop_cnt     = drop_q;
    assign bus.ovf_cnt      = ovf_q;
    assign bus.nearly_full  = nf_q;

endmodule

// File: tb/tb_action_egress.sv
// Directed bench for action_egress: expected words are queued when driven and checked as
// they leave the egress port; status outputs are checked at fixed points.
module tb_action_egress;

    typedef struct packed {
        logic [511:0] d;
        logic [7:0]   p;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    exp_t sb [$];

    logic         held_valid = 1'b0;
    logic [511:0] held_data;
    logic [7:0]   held_port;

    action_egress_if bus ();

    action_egress dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] exp_data(input logic [511:0] d, input logic [7:0] s);
`ifdef STATE_STAMP_EN
        return {s, d[503:0]};
`else
        return (s == s) ? d : d;
`endif
    endfunction

    // Drives one word for one cycle; keep=0 marks a word the bench knows will be lost.
    task automatic send_word(input logic [511:0] d, input logic [15:0] a, input logic [7:0] s,
                             input bit keep);
        exp_t e;
        bus.pkt_vld_in  = 1'b1;
        bus.pkt_data_in = d;
        bus.action_in   = a;
        bus.state_in    = s;
        if (keep && a != 16'h0000) begin
            e.d = exp_data(d, s);
            e.p = (a[15:8] != 8'h00) ? a[15:8] : 8'h80;
            sb.push_back(e);
        end
        tick();
        bus.pkt_vld_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    // Egress monitor: sampled on the falling edge, transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            held_valid <= 1'b0;
        end else if (bus.pkt_vld_out) begin
            if (held_valid) begin
                check("hold_data", bus.pkt_data_out, held_data);
                check("hold_port", bus.port_out, held_port);
            end
            if (bus.pkt_rdy_in) begin
                exp_t e;
                n_xfer++;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data", bus.pkt_data_out, e.d);
                    check("out_port", bus.port_out, e.p);
                end
                held_valid <= 1'b0;
            end else begin
                held_valid <= 1'b1;
                held_data  <= bus.pkt_data_out;
                held_port  <= bus.port_out;
            end
        end else begin
            held_valid <= 1'b0;
        end
    end

    initial begin
        int base;
        reset           = 1'b1;
        bus.pkt_vld_in  = 1'b0;
        bus.pkt_data_in = '0;
        bus.action_in   = '0;
        bus.state_in    = '0;
        bus.pkt_rdy_in  = 1'b1;
        tick();
        tick();
        check("rst_vld", bus.pkt_vld_out, 0);
        check("rst_data", bus.pkt_data_out, 0);
        check("rst_port", bus.port_out, 0);
        check("rst_drop", bus.drop_cnt, 0);
        check("rst_ovf", bus.ovf_cnt, 0);
        check("rst_nf", bus.nearly_full, 0);
        reset = 1'b0;
        tick();

        // Latency from an empty FIFO with ready high.
        send_word(512'h1, 16'h0200, 8'h00, 1'b1);
        check("lat_c1_vld", bus.pkt_vld_out, 0);
        tick();
        check("lat_c2_vld", bus.pkt_vld_out, 0);
        tick();
        check("lat_c3_vld", bus.pkt_vld_out, 1);
        check("lat_c3_port", bus.port_out, 8'h02);
        check("lat_c3_data", bus.pkt_data_out, 512'h1);
        repeat (3) tick();

        // Drop then forward.
        send_word(512'hDEAD, 16'h0000, 8'h00, 1'b1);
        repeat (4) tick();
        check("drop_cnt_1", bus.drop_cnt, 1);
        check("drop_no_out", n_xfer, 1);
        send_word(512'hBEEF, 16'h0100, 8'h11, 1'b1);
        drain();
        check("fwd_xfers", n_xfer, 2);

        // Punt to CPU port.
        send_word({8'hAA, 504'h1234_5678}, 16'h0003, 8'h05, 1'b1);
        drain();
        check("punt_xfers", n_xfer, 3);

        // Back-pressure: one word parked in the output, then a 20-word burst.
        bus.pkt_rdy_in = 1'b0;
        send_word(512'hA0, 16'h0400, 8'h00, 1'b1);
        repeat (3) tick();
        check("bp_parked_vld", bus.pkt_vld_out, 1);
        for (int i = 1; i <= 20; i++) begin
            send_word(512'(i) << 8, 16'(i) << 8, 8'(i), i <= 16);
            if (i == 13) check("nf_word13", bus.nearly_full, 0);
            if (i == 14) check("nf_word14", bus.nearly_full, 1);
        end
        check("bp_nf_full", bus.nearly_full, 1);
        check("bp_ovf", bus.ovf_cnt, 4);
        check("bp_drop", bus.drop_cnt, 1);
        bus.pkt_rdy_in = 1'b1;
        drain();
        check("bp_xfers", n_xfer, 20);
        check("bp_nf_clear", bus.nearly_full, 0);

        // Ready toggling every cycle.
        base = n_xfer;
        for (int c = 0; c < 40; c++) begin
            bus.pkt_rdy_in = c[0];
            if (c < 3) begin
                send_word(512'hC0 + 512'(c), 16'h0800 + 16'(c), 8'h00, 1'b1);
            end else begin
                tick();
            end
        end
        bus.pkt_rdy_in = 1'b1;
        drain();
        check("tog_xfers", n_xfer - base, 3);

        // Reset in SEND with five words queued.
        bus.pkt_rdy_in = 1'b0;
        for (int i = 0; i < 6; i++) send_word(512'hE0 + 512'(i), 16'h0300, 8'h00, 1'b1);
        tick();
        tick();
        check("pre_rst_vld", bus.pkt_vld_out, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_vld", bus.pkt_vld_out, 0);
        check("mid_rst_drop", bus.drop_cnt, 0);
        check("mid_rst_ovf", bus.ovf_cnt, 0);
        check("mid_rst_port", bus.port_out, 0);
        sb.delete();
        tick();
        tick();
        reset          = 1'b0;
        bus.pkt_rdy_in = 1'b1;
        base           = n_xfer;
        repeat (20) tick();
        check("post_rst_no_out", n_xfer - base, 0);
        check("post_rst_vld", bus.pkt_vld_out, 0);
        check("post_rst_nf", bus.nearly_full, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
